game_ctrl: RTL

Blackjack round controller, directly upstream of the result overlay stage. It sequences one round: deal, player turn, dealer turn, outcome. It requests cards from the card source over a req/valid handshake and keeps both hand totals. Its 3-bit `state` output drives the result overlay, which draws WIN, LOSE or DRAW for codes 3, 4 and 5.

---
 rtl/game_pkg.sv | 42 ++++
 rtl/hand_accum.sv | 58 +++++
 rtl/game_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the blackjack round controller and the result
// overlay: state encodings, hand constants, and the card scoring helpers.
package game_pkg;

    // Encodings are fixed: the result overlay decodes 3/4/5 as WIN/LOSE/DRAW.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAYER = 3'd1,
        ST_DEALER = 3'd2,
        ST_WIN    = 3'd3,
        ST_LOSE   = 3'd4,
        ST_DRAW   = 3'd5,
        ST_DEAL   = 3'd6
    } state_t;

    localparam logic [5:0] BLACKJACK = 6'd21;
    localparam logic [5:0] ACE_BONUS = 6'd10;

    // Highest hard total at which counting an ace as 11 does not bust.
    localparam logic [5:0] SOFT_LIMIT = BLACKJACK - ACE_BONUS;

    // Points added to the hard sum by one card; aces count 1 here and the
    // soft bonus is applied separately from the hand's ace flag.
    function automatic logic [5:0] card_points(input logic [3:0] rank);
        logic [5:0] pts;
        if (rank >= 4'd11 && rank <= 4'd13) begin
            pts = 6'd10;
        end else if (rank >= 4'd1 && rank <= 4'd10) begin
            pts = {2'b00, rank};
        end else begin
            pts = 6'd0;
        end
        return pts;
    endfunction

    // Ranks outside 1..13 are never accepted from the card source.
    function automatic logic card_legal(input logic [3:0] rank);
        return (rank != 4'd0) && (rank <= 4'd13);
    endfunction

endpackage

// File: rtl/hand_accum.sv
// hand_accum
// Accumulates one hand: registered hard total, ace flag and card count,
// with a combinational soft total.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          empty the hand (takes priority over add)
//   add          accept one card of rank `rank` this cycle
//   rank         card rank 1..13 (1 = ace)
//   soft_sum     hard total, plus 10 when an ace is held and it fits
//   count        number of cards held
module hand_accum
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       add,
    input  logic [3:0] rank,
    output logic [5:0] soft_sum,
    output logic [2:0] count
);

    logic [5:0] hard_q, hard_d;
    logic       ace_q,  ace_d;
    logic [2:0] count_q, count_d;

    always_comb begin
        hard_d  = hard_q;
        ace_d   = ace_q;
        count_d = count_q;
        if (clr) begin
            hard_d  = 6'd0;
            ace_d   = 1'b0;
            count_d = 3'd0;
        end else if (add) begin
            hard_d  = hard_q + card_points(rank);
            ace_d   = ace_q | (rank == 4'd1);
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hard_q  <= 6'd0;
            ace_q   <= 1'b0;
            count_q <= 3'd0;
        end else begin
            hard_q  <= hard_d;
            ace_q   <= ace_d;
            count_q <= count_d;
        end
    end

    // Only one ace can ever take the bonus, so a single flag suffices.
    assign soft_sum = (ace_q && hard_q <= SOFT_LIMIT) ? hard_q + ACE_BONUS : hard_q;
    assign count    = count_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl
// Blackjack round controller: deal, player turn, dealer turn, outcome.
// Requests cards over a req/valid handshake and keeps both hand totals.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   btn_start/hit/stand       one-cycle button pulses
//   card_valid, card_value    card source offer (rank 1..13)
//   card_req, card_to         card wanted, destination (0 player, 1 dealer)
//   state                     round state (state_t encoding)
//   player_sum, dealer_sum    soft totals
//   player_cards, dealer_cards cards held
module game_ctrl
    import game_pkg::*;
#(
    parameter int DEALER_STAND = 17,
    parameter int MAX_CARDS    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_hit,
    input  logic       btn_stand,
    input  logic       card_valid,
    input  logic [3:0] card_value,
    output logic       card_req,
    output logic       card_to,
    output logic [2:0] state,
    output logic [5:0] player_sum,
    output logic [5:0] dealer_sum,
    output logic [2:0] player_cards,
    output logic [2:0] dealer_cards
);

    localparam logic [5:0] STAND_SUM  = 6'(DEALER_STAND);
    localparam logic [2:0] CARD_LIMIT = 3'(MAX_CARDS);

    state_t     state_q, state_d;
    logic [1:0] deal_cnt_q, deal_cnt_d;
    logic       req_q, req_d;
    logic       to_q, to_d;

    logic       accept;
    logic       hands_clr;

    assign accept = req_q & card_valid & card_legal(card_value);

    hand_accum u_player (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (hands_clr),
        .add      (accept & ~to_q),
        .rank     (card_value),
        .soft_sum (player_sum),
        .count    (player_cards)
    );

    hand_accum u_dealer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (hands_clr),
        .add      (accept & to_q),
        .rank     (card_value),
        .soft_sum (dealer_sum),
        .count    (dealer_cards)
    );

    // Decisions are only taken while no request is outstanding, so they
    // always see totals that already include the last accepted card.
    always_comb begin
        state_d    = state_q;
        deal_cnt_d = deal_cnt_q;
        req_d      = req_q;
        to_d       = to_q;
        hands_clr  = 1'b0;

        if (accept) begin
            req_d = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE, ST_DRAW: begin
                if (btn_start) begin
                    hands_clr  = 1'b1;
                    state_d    = ST_DEAL;
                    deal_cnt_d = 2'd0;
                    req_d      = 1'b1;
                    to_d       = 1'b0;
                end
            end

            ST_DEAL: begin
                // req is raised on entry, so it is low here only in the
                // cycle right after a deal card was accepted.
                if (!req_q) begin
                    if (deal_cnt_q == 2'd3) begin
                        state_d = (player_sum == BLACKJACK) ? ST_DEALER : ST_PLAYER;
                    end else begin
                        deal_cnt_d = deal_cnt_q + 2'd1;
                        req_d      = 1'b1;
                        to_d       = ~deal_cnt_q[0];  // alternate player/dealer
                    end
                end
            end

            ST_PLAYER: begin
                if (!req_q) begin
                    if (player_sum > BLACKJACK) begin
                        state_d = ST_LOSE;
                    end else if (player_sum == BLACKJACK || player_cards == CARD_LIMIT) begin
                        state_d = ST_DEALER;
                    end else if (btn_stand) begin
                        state_d = ST_DEALER;
                    end else if (btn_hit) begin
                        req_d = 1'b1;
                        to_d  = 1'b0;
                    end
                end
            end

            ST_DEALER: begin
                if (!req_q) begin
                    if (dealer_sum < STAND_SUM && dealer_cards < CARD_LIMIT) begin
                        req_d = 1'b1;
                        to_d  = 1'b1;
                    end else if (dealer_sum > BLACKJACK) begin
                        state_d = ST_WIN;
                    end else if (player_sum > dealer_sum) begin
                        state_d = ST_WIN;
                    end else if (player_sum < dealer_sum) begin
                        state_d = ST_LOSE;
                    end else begin
                        state_d = ST_DRAW;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            deal_cnt_q <= 2'd0;
            req_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            deal_cnt_q <= deal_cnt_d;
            req_q      <= req_d;
            to_q       <= to_d;
        end
    end

    assign state    = state_q;
    assign card_req = req_q;
    assign card_to  = to_q;

endmodule
